// File: rtl/spoc_bdi_blocker.sv
`default_nettype none
// ============================================================================
// Module  : spoc_bdi_blocker
// Brief   : Packs 32-bit bdi words into byte-masked 64-bit blocks tagged with
//           size/type/last/eoi/partial flags on a valid/ready interface.
// Revision: 1.0
// ============================================================================
module spoc_bdi_blocker #(
  parameter int PW = 32,
  parameter int BW = 64,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] bdi,
  input  logic          bdi_valid,
  output logic          bdi_ready,
  input  logic [2:0]    bdi_size,
  input  logic          bdi_eot,
  input  logic          bdi_eoi,
  input  logic [TW-1:0] bdi_type,
  output logic [BW-1:0] blk_data,
  output logic [3:0]    blk_size,
  output logic [TW-1:0] blk_type,
  output logic          blk_last,
  output logic          blk_eoi,
  output logic          blk_partial,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic          proto_err
);

  typedef enum logic [1:0] {
    FILL_HI = 2'd0,
    FILL_LO = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_live;
  logic [BW-1:0] r_data, w_data_nxt;
  logic [3:0]    r_size, w_size_nxt;
  logic [TW-1:0] r_type, w_type_nxt;
  logic          r_last, w_last_nxt;
  logic          r_eoi, w_eoi_nxt;
  logic          r_partial, w_partial_nxt;
  logic          r_err, w_err_nxt;

  logic [2:0]    w_sz;
  logic [3:0]    w_sum;
  logic [PW-1:0] w_mask;
  logic          w_ready;
  logic          w_accept;
  logic          w_bad_size;

  // Oversized words count as full words; bytes beyond the count are zeroed.
  assign w_sz       = (bdi_size > 3'd4) ? 3'd4 : bdi_size;
  assign w_sum      = r_size + {1'b0, w_sz};
  assign w_bad_size = (bdi_size > 3'd4) || ((w_sz < 3'd4) && !bdi_eot);
  assign w_ready    = r_live && (r_state != HOLD);
  assign w_accept   = bdi_valid && w_ready;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PW / 8; i++) begin
      if (i < int'(w_sz)) w_mask[PW-1-8*i -: 8] = bdi[PW-1-8*i -: 8];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_size_nxt    = r_size;
    w_type_nxt    = r_type;
    w_last_nxt    = r_last;
    w_eoi_nxt     = r_eoi;
    w_partial_nxt = r_partial;
    w_err_nxt     = r_err;
    case (r_state)
      FILL_HI: begin
        if (w_accept) begin
          w_data_nxt    = {w_mask, {(BW-PW){1'b0}}};
          w_size_nxt    = {1'b0, w_sz};
          w_type_nxt    = bdi_type;
          w_last_nxt    = 1'b0;
          w_eoi_nxt     = 1'b0;
          w_partial_nxt = 1'b0;
          if (w_bad_size) w_err_nxt = 1'b1;
          if (bdi_eot || (w_sz < 3'd4)) begin
            w_last_nxt    = bdi_eot;
            w_eoi_nxt     = bdi_eoi;
            w_partial_nxt = ({1'b0, w_sz} < 4'd8);
            w_state_nxt   = HOLD;
          end else begin
            w_state_nxt   = FILL_LO;
          end
        end
      end
      FILL_LO: begin
        if (w_accept) begin
          w_data_nxt    = {r_data[BW-1:BW-PW], w_mask};
          w_size_nxt    = w_sum;
          w_last_nxt    = bdi_eot;
          w_eoi_nxt     = bdi_eoi;
          w_partial_nxt = (w_sum < 4'd8);
          if (w_bad_size || (bdi_type != r_type)) w_err_nxt = 1'b1;
          w_state_nxt   = HOLD;
        end
      end
      HOLD: begin
        if (blk_ready) w_state_nxt = FILL_HI;
      end
      default: w_state_nxt = FILL_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= FILL_HI;
      r_live    <= 1'b0;
      r_data    <= '0;
      r_size    <= '0;
      r_type    <= '0;
      r_last    <= 1'b0;
      r_eoi     <= 1'b0;
      r_partial <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_live    <= 1'b1;
      r_data    <= w_data_nxt;
      r_size    <= w_size_nxt;
      r_type    <= w_type_nxt;
      r_last    <= w_last_nxt;
      r_eoi     <= w_eoi_nxt;
      r_partial <= w_partial_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bdi_ready   = w_ready;
  assign blk_valid   = (r_state == HOLD);
  assign blk_data    = r_data;
  assign blk_size    = r_size;
  assign blk_type    = r_type;
  assign blk_last    = r_last;
  assign blk_eoi     = r_eoi;
  assign blk_partial = r_partial;
  assign proto_err   = r_err;

endmodule
`default_nettype wire
